// File: rtl/rv32i_lsu_pkg.sv
// rv32i_lsu_pkg: funct3 encodings, LSU state type and store byte-enable helper.
package rv32i_lsu_pkg;
    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    function automatic logic [3:0] calc_wstrb(input logic [2:0] f3, input logic [1:0] off);
        return (f3 == F3_B) ? 4'b0001 << off :
               (f3 == F3_H) ? (off[1] ? 4'b1100 : 4'b0011) :
               (f3 == F3_W) ? 4'b1111 : 4'b0000;
    endfunction
endpackage

// File: rtl/rv32i_load_align.sv
// rv32i_load_align: selects the addressed byte/half of a read word and sign/zero-extends it.
module rv32i_load_align
    import rv32i_lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    output logic [31:0] data
);
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b    = rdata[{off, 3'b000} +: 8];
        h    = off[1] ? rdata[31:16] : rdata[15:0];
        data = (funct3 == F3_B)  ? {{24{b[7]}}, b} :
               (funct3 == F3_BU) ? {24'b0, b} :
               (funct3 == F3_H)  ? {{16{h[15]}}, h} :
               (funct3 == F3_HU) ? {16'b0, h} : rdata;
    end
endmodule

// File: rtl/rv32i_lsu.sv
// rv32i_lsu: load/store unit running a req/ack data-memory transaction per access,
// stalling the pipeline until it completes or times out.
module rv32i_lsu
    import rv32i_lsu_pkg::*;
#(
    parameter  int TIMEOUT_CYCLES = 16,
    localparam int CNT_W          = $clog2(TIMEOUT_CYCLES) + 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic [31:0] mem_read_data,
    output logic        lsu_stall,
    output logic        misaligned,
    output logic        bus_err
);
    state_t           state, next;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       f3_q;
    logic [1:0]       off_q;
    logic [31:0]      load_data;
    logic             illegal, mis_comb, try_acc, start, timeout;

    rv32i_load_align u_align (
        .rdata  (dmem_rdata),
        .funct3 (f3_q),
        .off    (off_q),
        .data   (load_data)
    );

    // A store wins when both mem_read and mem_write are set, so legality follows mem_write.
    always_comb begin
        illegal    = mem_write ? (funct3 > F3_W) : (funct3 == 3'd3 || funct3[2:1] == 2'b11);
        mis_comb   = illegal | (funct3[1:0] == 2'b01 & addr[0]) | (funct3 == F3_W & addr[1:0] != 2'b00);
        try_acc    = ex_valid & (mem_read | mem_write) & (state == IDLE);
        start      = try_acc & ~mis_comb;
        misaligned = try_acc & mis_comb;
        timeout    = cnt == CNT_W'(TIMEOUT_CYCLES - 1);
        dmem_req   = state == WAIT;
        lsu_stall  = start | dmem_req;
        next       = (state == IDLE) ? (start ? WAIT : IDLE) :
                     (state == WAIT) ? ((dmem_ack | timeout) ? DONE : WAIT) : IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            f3_q          <= '0;
            off_q         <= '0;
            dmem_we       <= 1'b0;
            dmem_addr     <= '0;
            dmem_wstrb    <= '0;
            dmem_wdata    <= '0;
            mem_read_data <= '0;
            bus_err       <= 1'b0;
        end else begin
            state   <= next;
            bus_err <= dmem_req & ~dmem_ack & timeout;
            if (start) begin
                cnt        <= '0;
                f3_q       <= funct3;
                off_q      <= addr[1:0];
                dmem_we    <= mem_write;
                dmem_addr  <= {addr[31:2], 2'b00};
                dmem_wstrb <= mem_write ? calc_wstrb(funct3, addr[1:0]) : 4'b0000;
                dmem_wdata <= (funct3 == F3_B) ? {4{store_data[7:0]}} :
                              (funct3 == F3_H) ? {2{store_data[15:0]}} : store_data;
            end else if (dmem_req) begin
                cnt <= cnt + 1'b1;
                if (dmem_ack)
                    mem_read_data <= dmem_we ? 32'b0 : load_data;
                else if (timeout)
                    mem_read_data <= 32'b0;
            end
        end
    end
endmodule

// File: tb/tb_rv32i_lsu.sv
// tb_rv32i_lsu: table-driven and randomized checks of rv32i_lsu against an arithmetic model.
module tb_rv32i_lsu;
    localparam int TO = 16;

    logic        clk = 0, rst;
    logic        ex_valid, mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data, dmem_rdata;
    logic        dmem_ack;
    logic        dmem_req, dmem_we, lsu_stall, misaligned, bus_err;
    logic [31:0] dmem_addr, dmem_wdata, mem_read_data;
    logic [3:0]  dmem_wstrb;

    int errors = 0, checks = 0;

    rv32i_lsu #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .addr(addr), .store_data(store_data), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .mem_read_data(mem_read_data),
        .lsu_stall(lsu_stall), .misaligned(misaligned), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic        rd, wr;
        logic [31:0] a, sd, rdat;
        int          ack_at;
        logic [31:0] e_addr;
        logic [3:0]  e_wstrb;
        logic [31:0] e_wdata;
        logic        e_we;
        logic [31:0] e_rd;
        logic        e_err;
    } vec_t;

    typedef struct {
        logic [2:0]  f3;
        logic        rd, wr;
        logic [31:0] a;
    } mis_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] r);
        logic [31:0] w;
        w = (f3[1:0] == 2'd1) ? r >> (16 * a[1]) : r >> (8 * a[1:0]);
        case (f3)
            3'd0:    return 32'($signed(w[7:0]));
            3'd1:    return 32'($signed(w[15:0]));
            3'd4:    return {24'b0, w[7:0]};
            3'd5:    return {16'b0, w[15:0]};
            default: return r;
        endcase
    endfunction

    function automatic logic [3:0] m_wstrb(input logic [2:0] f3, input logic [31:0] a);
        case (f3)
            3'd0:    return 4'(1 << a[1:0]);
            3'd1:    return a[1] ? 4'hC : 4'h3;
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
        case (f3)
            3'd0:    return {24'b0, sd[7:0]} * 32'h01010101;
            3'd1:    return {16'b0, sd[15:0]} * 32'h00010001;
            default: return sd;
        endcase
    endfunction

    task automatic idle_inputs();
        ex_valid = 0; mem_read = 0; mem_write = 0; funct3 = 0; addr = 0; store_data = 0;
    endtask

    task automatic run(input vec_t v, input bit poke);
        int cyc, stalls, exp_req;
        exp_req = (v.ack_at < 0) ? TO : v.ack_at + 1;
        @(negedge clk);
        ex_valid = 1; mem_read = v.rd; mem_write = v.wr; funct3 = v.f3; addr = v.a; store_data = v.sd;
        #1;
        chk("start_stall", 32'(lsu_stall), 1);
        chk("start_mis", 32'(misaligned), 0);
        stalls = 1;
        @(negedge clk);
        idle_inputs();
        cyc = 0;
        while (dmem_req && cyc < 40) begin
            if (cyc == 0) begin
                chk("dmem_addr", dmem_addr, v.e_addr);
                chk("dmem_wstrb", 32'(dmem_wstrb), 32'(v.e_wstrb));
                chk("dmem_we", 32'(dmem_we), 32'(v.e_we));
                if (v.e_we) chk("dmem_wdata", dmem_wdata, v.e_wdata);
            end
            stalls += int'(lsu_stall);
            dmem_rdata = v.rdat;
            dmem_ack = (cyc == v.ack_at);
            @(negedge clk);
            cyc++;
        end
        dmem_ack = 0;
        chk("req_cycles", 32'(cyc), 32'(exp_req));
        chk("stall_cycles", 32'(stalls), 32'(exp_req + 1));
        chk("done_stall", 32'(lsu_stall), 0);
        chk("done_rdata", mem_read_data, v.e_rd);
        chk("done_bus_err", 32'(bus_err), 32'(v.e_err));
        if (poke) begin
            ex_valid = 1; mem_read = 1; funct3 = 3'd2; addr = 32'h100;
            #1 chk("done_nostart", 32'(lsu_stall), 0);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        chk("idle_req", 32'(dmem_req), 0);
        chk("idle_bus_err", 32'(bus_err), 0);
        chk("held_rdata", mem_read_data, v.e_rd);
    endtask

    initial begin
        vec_t vt[9];
        mis_t mt[8];
        vec_t v;
        rst = 1; dmem_ack = 0; dmem_rdata = 0;
        idle_inputs();

        vt[0] = '{3'd2, 1'b0, 1'b1, 32'h1004, 32'hDEADBEEF, 32'h0,        1, 32'h1004, 4'hF, 32'hDEADBEEF, 1'b1, 32'h0,        1'b0};
        vt[1] = '{3'd0, 1'b1, 1'b0, 32'h2003, 32'h0,        32'h80FF1234, 0, 32'h2000, 4'h0, 32'h0,        1'b0, 32'hFFFFFF80, 1'b0};
        vt[2] = '{3'd4, 1'b1, 1'b0, 32'h2003, 32'h0,        32'h80FF1234, 0, 32'h2000, 4'h0, 32'h0,        1'b0, 32'h00000080, 1'b0};
        vt[3] = '{3'd5, 1'b1, 1'b0, 32'h2002, 32'h0,        32'h80FF1234, 0, 32'h2000, 4'h0, 32'h0,        1'b0, 32'h000080FF, 1'b0};
        vt[4] = '{3'd1, 1'b0, 1'b1, 32'h3002, 32'h0000ABCD, 32'h0,        0, 32'h3000, 4'hC, 32'hABCDABCD, 1'b1, 32'h0,        1'b0};
        vt[5] = '{3'd0, 1'b0, 1'b1, 32'h3001, 32'h0000005A, 32'h0,        2, 32'h3000, 4'h2, 32'h5A5A5A5A, 1'b1, 32'h0,        1'b0};
        vt[6] = '{3'd2, 1'b1, 1'b0, 32'h5000, 32'h0,        32'hAAAA5555, -1, 32'h5000, 4'h0, 32'h0,       1'b0, 32'h0,        1'b1};
        vt[7] = '{3'd2, 1'b1, 1'b1, 32'h6008, 32'h12345678, 32'hFFFFFFFF, 1, 32'h6008, 4'hF, 32'h12345678, 1'b1, 32'h0,        1'b0};
        vt[8] = '{3'd1, 1'b1, 1'b0, 32'h2002, 32'h0,        32'h80FF1234, 3, 32'h2000, 4'h0, 32'h0,        1'b0, 32'hFFFF80FF, 1'b0};

        mt[0] = '{3'd2, 1'b1, 1'b0, 32'h4001};
        mt[1] = '{3'd3, 1'b1, 1'b0, 32'h4000};
        mt[2] = '{3'd1, 1'b1, 1'b0, 32'h4001};
        mt[3] = '{3'd1, 1'b0, 1'b1, 32'h4003};
        mt[4] = '{3'd2, 1'b0, 1'b1, 32'h4002};
        mt[5] = '{3'd4, 1'b0, 1'b1, 32'h4000};
        mt[6] = '{3'd6, 1'b1, 1'b0, 32'h4000};
        mt[7] = '{3'd7, 1'b1, 1'b0, 32'h4000};

        #12;
        chk("rst_req", 32'(dmem_req), 0);
        chk("rst_we", 32'(dmem_we), 0);
        chk("rst_wstrb", 32'(dmem_wstrb), 0);
        chk("rst_addr", dmem_addr, 0);
        chk("rst_wdata", dmem_wdata, 0);
        chk("rst_rdata", mem_read_data, 0);
        chk("rst_stall", 32'(lsu_stall), 0);
        chk("rst_mis", 32'(misaligned), 0);
        chk("rst_bus_err", 32'(bus_err), 0);
        @(negedge clk);
        rst = 0;

        foreach (vt[i]) run(vt[i], 1'b0);

        foreach (mt[i]) begin
            @(negedge clk);
            ex_valid = 1; mem_read = mt[i].rd; mem_write = mt[i].wr; funct3 = mt[i].f3; addr = mt[i].a;
            #1;
            chk("mis_pulse", 32'(misaligned), 1);
            chk("mis_stall", 32'(lsu_stall), 0);
            chk("mis_req", 32'(dmem_req), 0);
            @(negedge clk);
            idle_inputs();
            #1;
            chk("mis_clear", 32'(misaligned), 0);
            chk("mis_noreq", 32'(dmem_req), 0);
        end

        @(negedge clk);
        mem_read = 1; funct3 = 3'd2; addr = 32'h4001;
        #1 chk("mis_novalid", 32'(misaligned), 0);
        idle_inputs();

        // Reset in the third WAIT cycle, then a stray ack once back in IDLE.
        @(negedge clk);
        ex_valid = 1; mem_read = 1; funct3 = 3'd2; addr = 32'h7000;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_req", 32'(dmem_req), 1);
        rst = 1;
        #1;
        chk("mid_rst_req", 32'(dmem_req), 0);
        chk("mid_rst_stall", 32'(lsu_stall), 0);
        @(negedge clk);
        rst = 0; dmem_ack = 1; dmem_rdata = 32'h12345678;
        @(negedge clk);
        dmem_ack = 0;
        chk("late_ack_req", 32'(dmem_req), 0);
        chk("late_ack_rdata", mem_read_data, 0);
        chk("late_ack_err", 32'(bus_err), 0);
        @(negedge clk);
        chk("late_ack_req2", 32'(dmem_req), 0);
        chk("late_ack_err2", 32'(bus_err), 0);

        for (int i = 0; i < 40; i++) begin
            logic [2:0] pick [5];
            pick = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
            v.f3 = pick[$urandom_range(0, 4)];
            v.wr = 1'($urandom_range(0, 1));
            v.rd = v.wr ? 1'($urandom_range(0, 1)) : 1'b1;
            if (v.wr && v.f3 > 3'd2) v.f3 = v.f3 - 3'd4;
            v.a = $urandom;
            if (v.f3[1:0] == 2'd1) v.a[0] = 1'b0;
            if (v.f3 == 3'd2) v.a[1:0] = 2'b00;
            v.sd = $urandom;
            v.rdat = $urandom;
            v.ack_at = $urandom_range(0, 4);
            v.e_addr = v.a & ~32'h3;
            v.e_we = v.wr;
            v.e_wstrb = v.wr ? m_wstrb(v.f3, v.a) : 4'h0;
            v.e_wdata = m_wdata(v.f3, v.sd);
            v.e_rd = v.wr ? 32'h0 : m_load(v.f3, v.a, v.rdat);
            v.e_err = 1'b0;
            run(v, i == 5);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
